alu_cmd_sequencer: RTL and testbench

Upstream command front-end for the 8-bit ALU datapath. Accepts complete ALU commands (opcode, operand A, operand B) over a valid/ready interface and buffers them in a small FIFO. Sequences each command into the datapath as store_a, then store_b, then start. Captures result/overflow on alu_done and returns them on a valid/ready response interface, with a timeout guard against a datapath that never completes.

---
 rtl/alu_cmd_sequencer_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 59 +++++
 rtl/alu_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command front-end.
//   - alu_op_e    : opcode encoding, common with the ALU datapath
//   - seq_state_e : sequencer FSM state encoding
//   - ptr_width() : FIFO pointer width (index bits + one wrap bit)
package alu_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PAR  = 2'b10,
        OP_COMP = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_A    = 3'd1,
        ST_LOAD_B    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RESP      = 3'd5
    } seq_state_e;

    // The extra MSB distinguishes full from empty when the index bits match.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO.
//   clk, rst_n   : clock, async active-low reset (pointers only)
//   push, wdata  : write strobe / data; ignored while full
//   pop          : read strobe; ignored while empty
//   rdata        : head entry (combinational, valid while !empty)
//   full, empty  : occupancy flags derived from the registered pointers
module alu_cmd_fifo
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
    logic                         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the ALU datapath. Buffers {opcode, A, B} commands,
// drives each one into the datapath as store_a, store_b, start, waits for
// alu_done (or a timeout) and holds the result on a valid/ready response.
//   cmd_*        : command valid/ready input channel (cmd_ready = !full)
//   alu_data, opcode_value, store_a, store_b, start : registered datapath drive
//   alu_done, result, overflow_def : datapath completion inputs
//   rsp_*        : registered response channel; rsp_error flags a timeout
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_opcode,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic [DATA_WIDTH-1:0] alu_data,
    output logic [1:0]            opcode_value,
    output logic                  store_a,
    output logic                  store_b,
    output logic                  start,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow_def,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_error
);

    localparam int CMD_W = 2 + 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0] fifo_head;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata ({cmd_opcode, cmd_a, cmd_b}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Readiness comes from the registered full flag only, so a same-cycle
    // pop never opens the door for a push into a full FIFO.
    assign cmd_ready = !fifo_full;

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] alu_data_q, alu_data_d;
    logic [1:0]            opcode_q, opcode_d;
    logic                  store_a_q, store_a_d;
    logic                  store_b_q, store_b_d;
    logic                  start_q, start_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_overflow_q, rsp_overflow_d;
    logic                  rsp_error_q, rsp_error_d;

    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty && !rsp_valid_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        b_d            = b_q;
        alu_data_d     = alu_data_q;
        opcode_d       = opcode_q;
        store_a_d      = 1'b0;
        store_b_d      = 1'b0;
        start_d        = 1'b0;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_error_d    = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    state_d    = ST_LOAD_A;
                    opcode_d   = fifo_head[CMD_W-1 -: 2];
                    alu_data_d = fifo_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
                    b_d        = fifo_head[DATA_WIDTH-1:0];
                    store_a_d  = 1'b1;
                    cnt_d      = '0;
                end
            end
            ST_LOAD_A: begin
                state_d    = ST_LOAD_B;
                alu_data_d = b_q;
                store_b_d  = 1'b1;
            end
            ST_LOAD_B: begin
                state_d = ST_START;
                start_d = 1'b1;
            end
            ST_START: begin
                // The counter tallies every cycle start is high, START included,
                // so a dead datapath sees start for exactly TIMEOUT cycles.
                state_d = ST_WAIT_DONE;
                start_d = 1'b1;
                cnt_d   = CNT_W'(1);
            end
            ST_WAIT_DONE: begin
                if (alu_done) begin
                    state_d        = ST_RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = result;
                    rsp_overflow_d = overflow_def;
                    rsp_error_d    = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d        = ST_RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_error_d    = 1'b1;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            b_q            <= '0;
            alu_data_q     <= '0;
            opcode_q       <= '0;
            store_a_q      <= 1'b0;
            store_b_q      <= 1'b0;
            start_q        <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            b_q            <= b_d;
            alu_data_q     <= alu_data_d;
            opcode_q       <= opcode_d;
            store_a_q      <= store_a_d;
            store_b_q      <= store_b_d;
            start_q        <= start_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_error_q    <= rsp_error_d;
        end
    end

    assign alu_data     = alu_data_q;
    assign opcode_value = opcode_q;
    assign store_a      = store_a_q;
    assign store_b      = store_b_q;
    assign start        = start_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural datapath.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_opcode = 2'b00;
    logic [DW-1:0] cmd_a = '0, cmd_b = '0;
    logic [DW-1:0] alu_data;
    logic [1:0]    opcode_value;
    logic          store_a, store_b, start;
    logic          alu_done;
    logic [DW-1:0] result;
    logic          overflow_def;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow, rsp_error;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_data(alu_data), .opcode_value(opcode_value),
        .store_a(store_a), .store_b(store_b), .start(start),
        .alu_done(alu_done), .result(result), .overflow_def(overflow_def),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_error(rsp_error)
    );

    // Datapath model: latches operands on the strobes, answers dp_delay cycles
    // after start rises unless dp_never is set. force_done injects alu_done.
    logic [DW-1:0] dp_a = '0, dp_b = '0;
    logic [1:0]    dp_op = 2'b00;
    int            dp_cnt = 0;
    int            dp_delay = 2;
    logic          dp_never = 1'b0;
    logic          force_done = 1'b0;
    logic [DW-1:0] force_result = '0;
    logic [DW:0]   dp_sum;

    always @(posedge clk) begin
        if (store_a) begin dp_a <= alu_data; dp_op <= opcode_value; end
        if (store_b) dp_b <= alu_data;
        dp_cnt <= start ? dp_cnt + 1 : 0;
    end

    always_comb begin
        dp_sum = '0;
        case (dp_op)
            2'b00:   dp_sum = {1'b0, dp_a} + {1'b0, dp_b};
            2'b01:   dp_sum = {1'b0, dp_a} - {1'b0, dp_b};
            default: dp_sum = {1'b0, dp_a ^ dp_b};
        endcase
    end

    assign alu_done     = force_done | (start && !dp_never && dp_cnt == dp_delay);
    assign result       = force_done ? force_result : dp_sum[DW-1:0];
    assign overflow_def = force_done ? 1'b0 : dp_sum[DW];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_cmd(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit done = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready === 1'b1) begin
                @(negedge clk);
                done = 1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!done) $display("FAIL push_accept: got not accepted, expected accepted");
        else n_pass++;
    endtask

    task automatic wait_rsp(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({store_a, store_b, start, rsp_valid, rsp_error, rsp_overflow} !== 6'b0)
            $display("FAIL reset_ctl: got %b expected 000000",
                     {store_a, store_b, start, rsp_valid, rsp_error, rsp_overflow});
        else n_pass++;
        n_checks++;
        if ({alu_data, opcode_value, rsp_result} !== 18'h0)
            $display("FAIL reset_data: got %h expected 0", {alu_data, opcode_value, rsp_result});
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        bit ok;
        rsp_ready = 1'b0;
        push_cmd(OP_ADD, 8'h05, 8'h03);
        n_checks++;
        if ({store_a, store_b, start} !== 3'b000)
            $display("FAIL add_idle: got %b expected 000", {store_a, store_b, start});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({store_a, store_b, start, alu_data, opcode_value} !== {3'b100, 8'h05, 2'b00})
            $display("FAIL add_load_a: got %h expected %h",
                     {store_a, store_b, start, alu_data, opcode_value}, {3'b100, 8'h05, 2'b00});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({store_a, store_b, start, alu_data, opcode_value} !== {3'b010, 8'h03, 2'b00})
            $display("FAIL add_load_b: got %h expected %h",
                     {store_a, store_b, start, alu_data, opcode_value}, {3'b010, 8'h03, 2'b00});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({store_a, store_b, start, opcode_value} !== {3'b001, 2'b00})
            $display("FAIL add_start: got %b expected 00100", {store_a, store_b, start, opcode_value});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({start, rsp_valid} !== 2'b10)
            $display("FAIL add_wait: got %b expected 10", {start, rsp_valid});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, start, rsp_result, rsp_overflow, rsp_error} !== {2'b10, 8'h08, 2'b00})
            $display("FAIL add_rsp: got %h expected %h",
                     {rsp_valid, start, rsp_result, rsp_overflow, rsp_error}, {2'b10, 8'h08, 2'b00});
        else n_pass++;
        handshake();
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL add_rsp_drop: got %b expected 0", rsp_valid);
        else n_pass++;
        wait_rsp(1, ok); // rsp_valid must stay low with an empty queue
        n_checks++;
        if (ok) $display("FAIL add_no_extra: got extra response, expected none");
        else n_pass++;
    endtask

    task automatic test_sub();
        bit ok;
        push_cmd(OP_SUB, 8'h00, 8'h01);
        @(negedge clk);
        n_checks++;
        if ({store_a, opcode_value, alu_data} !== {1'b1, 2'b01, 8'h00})
            $display("FAIL sub_load_a: got %h expected %h", {store_a, opcode_value, alu_data}, {1'b1, 2'b01, 8'h00});
        else n_pass++;
        wait_rsp(40, ok);
        n_checks++;
        if (!ok || {rsp_result, rsp_overflow, rsp_error} !== {8'hFF, 2'b10})
            $display("FAIL sub_rsp: got ok=%0d %h expected ok=1 %h", ok, {rsp_result, rsp_overflow, rsp_error}, {8'hFF, 2'b10});
        else n_pass++;
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok, held;
        int got;
        logic [DW-1:0] er [5];
        logic          eo [5];
        er = '{8'h03, 8'h00, 8'h05, 8'h00, 8'hFE};
        eo = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rsp_ready = 1'b0;
        push_cmd(OP_ADD, 8'h01, 8'h02);
        push_cmd(OP_ADD, 8'h80, 8'h80);
        push_cmd(OP_SUB, 8'h09, 8'h04);
        push_cmd(OP_ADD, 8'hFF, 8'h01);
        push_cmd(OP_SUB, 8'h03, 8'h05);
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL b2b_full: got cmd_ready=%b expected 0", cmd_ready);
        else n_pass++;
        wait_rsp(60, ok);
        held = ok;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 8'h03 || start !== 1'b0) held = 0;
        end
        n_checks++;
        if (!held) $display("FAIL b2b_hold: got valid=%b result=%h expected valid=1 result=03", rsp_valid, rsp_result);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL b2b_still_full: got %b expected 0", cmd_ready);
        else n_pass++;
        rsp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 300 && got < 5; i++) begin
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if ({rsp_result, rsp_overflow, rsp_error} !== {er[got], eo[got], 1'b0})
                    $display("FAIL b2b_rsp%0d: got %h expected %h", got,
                             {rsp_result, rsp_overflow, rsp_error}, {er[got], eo[got], 1'b0});
                else n_pass++;
                got++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (got != 5) $display("FAIL b2b_count: got %0d expected 5", got);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        dp_never = 1'b1;
        rsp_ready = 1'b0;
        push_cmd(OP_ADD, 8'h07, 8'h07);
        push_cmd(OP_SUB, 8'h09, 8'h04);
        hi = 0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1; break; end
            if (start === 1'b1) hi++;
            @(negedge clk);
        end
        n_checks++;
        if (!ok || hi != 16) $display("FAIL to_start_len: got ok=%0d cycles=%0d expected ok=1 cycles=16", ok, hi);
        else n_pass++;
        n_checks++;
        if ({rsp_result, rsp_overflow, rsp_error} !== {8'h00, 2'b01})
            $display("FAIL to_rsp: got %h expected %h", {rsp_result, rsp_overflow, rsp_error}, {8'h00, 2'b01});
        else n_pass++;
        dp_never = 1'b0;
        handshake();
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL to_drop: got %b expected 0", rsp_valid);
        else n_pass++;
        wait_rsp(40, ok);
        n_checks++;
        if (!ok || {rsp_result, rsp_overflow, rsp_error} !== {8'h05, 2'b00})
            $display("FAIL to_next: got ok=%0d %h expected ok=1 %h", ok, {rsp_result, rsp_overflow, rsp_error}, {8'h05, 2'b00});
        else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid();
        bit quiet;
        dp_never = 1'b1;
        rsp_ready = 1'b0;
        push_cmd(OP_ADD, 8'h01, 8'h01);
        push_cmd(OP_ADD, 8'h02, 8'h02);
        push_cmd(OP_ADD, 8'h03, 8'h03);
        for (int i = 0; i < 50; i++) begin
            if (start === 1'b1) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (start !== 1'b1) $display("FAIL rm_in_wait: got start=%b expected 1", start);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({store_a, store_b, start, rsp_valid, cmd_ready} !== 5'b00001)
            $display("FAIL rm_abort: got %b expected 00001", {store_a, store_b, start, rsp_valid, cmd_ready});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        dp_never = 1'b0;
        rsp_ready = 1'b1;
        quiet = 1;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || start !== 1'b0 || store_a !== 1'b0 || store_b !== 1'b0) quiet = 0;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (!quiet) $display("FAIL rm_discard: got activity after reset, expected none");
        else n_pass++;
    endtask

    task automatic test_spurious_done();
        bit ok;
        rsp_ready = 1'b0;
        force_result = 8'hAA;
        force_done = 1'b1;
        repeat (3) @(negedge clk);
        force_done = 1'b0;
        n_checks++;
        if ({rsp_valid, store_a, store_b, start} !== 4'b0000)
            $display("FAIL sp_idle: got %b expected 0000", {rsp_valid, store_a, store_b, start});
        else n_pass++;
        push_cmd(OP_ADD, 8'h10, 8'h20);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (store_b !== 1'b1) $display("FAIL sp_load_b: got store_b=%b expected 1", store_b);
        else n_pass++;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        n_checks++;
        if ({start, rsp_valid} !== 2'b10)
            $display("FAIL sp_start: got %b expected 10", {start, rsp_valid});
        else n_pass++;
        wait_rsp(40, ok);
        n_checks++;
        if (!ok || {rsp_result, rsp_overflow, rsp_error} !== {8'h30, 2'b00})
            $display("FAIL sp_rsp: got ok=%0d %h expected ok=1 %h", ok, {rsp_result, rsp_overflow, rsp_error}, {8'h30, 2'b00});
        else n_pass++;
        handshake();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_spurious_done();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
